// File: rtl/dds_cmd_pkg.sv
// Shared definitions for the DDS command sequencer: frame layout, opcodes,
// reply tags, readback indices and the sequencer state encoding.
package dds_cmd_pkg;

  localparam int unsigned FRAME_W = 32;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned PAY_W   = 24;
  localparam int unsigned REPLY_W = 24;
  localparam int unsigned FREQ_W  = 32;
  localparam int unsigned LO_W    = 24;
  localparam int unsigned PHASE_W = 12;
  localparam int unsigned AMP_W   = 10;
  localparam int unsigned WAVE_W  = 2;

  localparam logic [OPC_W-1:0] OP_INIT     = 8'h01;
  localparam logic [OPC_W-1:0] OP_FREQ_LO  = 8'h10;
  localparam logic [OPC_W-1:0] OP_FREQ_HI  = 8'h11;
  localparam logic [OPC_W-1:0] OP_PHASE    = 8'h12;
  localparam logic [OPC_W-1:0] OP_AMPL     = 8'h13;
  localparam logic [OPC_W-1:0] OP_MODE     = 8'h14;
  localparam logic [OPC_W-1:0] OP_READBACK = 8'h20;

  localparam logic [7:0] ACK_TAG = 8'hA5;
  localparam logic [7:0] ERR_TAG = 8'hEE;

  localparam logic [7:0] RB_FREQ_LO  = 8'd0;
  localparam logic [7:0] RB_FREQ_HI  = 8'd1;
  localparam logic [7:0] RB_PHASE    = 8'd2;
  localparam logic [7:0] RB_AMPL     = 8'd3;
  localparam logic [7:0] RB_MODE     = 8'd4;
  localparam logic [7:0] RB_COUNTERS = 8'd5;
  localparam logic [REPLY_W-1:0] RB_INVALID = 24'hEEEEEE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_REPLY = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

endpackage

// File: rtl/dds_cmd_decode.sv
// Combinational command decoder: maps one frame plus the current DDS
// registers onto next register values, commit/error flags and the reply word.
module dds_cmd_decode
  import dds_cmd_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic [FRAME_W-1:0] cmd_i,
  input  logic [FREQ_W-1:0]  freq_i,
  input  logic [PHASE_W-1:0] phase_i,
  input  logic [AMP_W-1:0]   amp_i,
  input  logic [WAVE_W-1:0]  wave_i,
  input  logic               en_i,
  input  logic [LO_W-1:0]    lo_i,
  input  logic [CNT_W-1:0]   err_cnt_i,
  input  logic [CNT_W-1:0]   drop_cnt_i,
  output logic [FREQ_W-1:0]  freq_o,
  output logic [PHASE_W-1:0] phase_o,
  output logic [AMP_W-1:0]   amp_o,
  output logic [WAVE_W-1:0]  wave_o,
  output logic               en_o,
  output logic [LO_W-1:0]    lo_o,
  output logic               update_o,
  output logic               error_o,
  output logic [REPLY_W-1:0] reply_o
);

  logic [OPC_W-1:0] opc;
  logic [PAY_W-1:0] pay;
  logic [CNT_W-1:0] err_inc;

  assign opc = cmd_i[OPC_W-1:0];
  assign pay = cmd_i[FRAME_W-1:OPC_W];
  // The error reply reports the counter as it will read after this frame.
  assign err_inc = (&err_cnt_i) ? err_cnt_i : err_cnt_i + CNT_W'(1);

  always_comb begin
    freq_o   = freq_i;
    phase_o  = phase_i;
    amp_o    = amp_i;
    wave_o   = wave_i;
    en_o     = en_i;
    lo_o     = lo_i;
    update_o = 1'b0;
    error_o  = 1'b0;
    reply_o  = {ACK_TAG, opc, 8'h00};
    case (opc)
      OP_INIT:    ;
      OP_FREQ_LO: lo_o = pay;
      OP_FREQ_HI: begin
        freq_o   = {pay[7:0], lo_i};
        update_o = 1'b1;
      end
      OP_PHASE: begin
        phase_o  = pay[PHASE_W-1:0];
        update_o = 1'b1;
      end
      OP_AMPL: begin
        amp_o    = pay[AMP_W-1:0];
        update_o = 1'b1;
      end
      OP_MODE: begin
        wave_o   = pay[WAVE_W-1:0];
        en_o     = pay[8];
        update_o = 1'b1;
      end
      OP_READBACK: begin
        case (pay[7:0])
          RB_FREQ_LO:  reply_o = freq_i[23:0];
          RB_FREQ_HI:  reply_o = {16'h0, freq_i[31:24]};
          RB_PHASE:    reply_o = {12'h0, phase_i};
          RB_AMPL:     reply_o = {14'h0, amp_i};
          RB_MODE:     reply_o = {15'h0, en_i, 6'h0, wave_i};
          RB_COUNTERS: reply_o = {8'h0, 8'(drop_cnt_i), 8'(err_cnt_i)};
          default:     reply_o = RB_INVALID;
        endcase
      end
      default: begin
        error_o = 1'b1;
        reply_o = {ERR_TAG, opc, 8'(err_inc)};
      end
    endcase
  end

endmodule

// File: rtl/dds_cmd_controller.sv
// SPI-to-DDS command sequencer: accepts one frame, decodes it into the DDS
// configuration registers and queues a reply word with a bounded wait.
module dds_cmd_controller
  import dds_cmd_pkg::*;
#(
  parameter int unsigned       REPLY_TIMEOUT = 65535,
  parameter logic [AMP_W-1:0]  AMP_RESET     = 10'h3FF,
  parameter int unsigned       CNT_W         = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rd_data_available,
  input  logic [FRAME_W-1:0] rd_data,
  output logic               rd_ack,
  input  logic               wr_buffer_free,
  output logic               wr_en,
  output logic [REPLY_W-1:0] wr_data,
  output logic [FREQ_W-1:0]  freq_word,
  output logic [PHASE_W-1:0] phase_word,
  output logic [AMP_W-1:0]   amplitude,
  output logic [WAVE_W-1:0]  wave_sel,
  output logic               dds_enable,
  output logic               cfg_update,
  output logic [CNT_W-1:0]   err_cnt,
  output logic [CNT_W-1:0]   drop_cnt,
  output logic               busy
);

  localparam int unsigned TMO_W = (REPLY_TIMEOUT > 1) ? $clog2(REPLY_TIMEOUT) : 1;

  state_e               state_q, state_d;
  logic [FRAME_W-1:0]   cmd_q;
  logic [LO_W-1:0]      lo_q;
  logic [FREQ_W-1:0]    freq_q;
  logic [PHASE_W-1:0]   phase_q;
  logic [AMP_W-1:0]     amp_q;
  logic [WAVE_W-1:0]    wave_q;
  logic                 en_q;
  logic [CNT_W-1:0]     err_q, drop_q;
  logic [REPLY_W-1:0]   reply_q, wr_data_q;
  logic [TMO_W-1:0]     tmo_q;
  logic                 rd_ack_q, rd_ack_d;
  logic                 wr_en_q, wr_en_d;
  logic                 cfg_upd_q, cfg_upd_d;
  logic                 busy_q, busy_d;
  logic                 tmo_hit_c, drop_hit_c;

  logic [FREQ_W-1:0]    dec_freq;
  logic [PHASE_W-1:0]   dec_phase;
  logic [AMP_W-1:0]     dec_amp;
  logic [WAVE_W-1:0]    dec_wave;
  logic                 dec_en, dec_upd, dec_err;
  logic [LO_W-1:0]      dec_lo;
  logic [REPLY_W-1:0]   dec_reply;

  dds_cmd_decode #(.CNT_W(CNT_W)) u_decode (
    .cmd_i      (cmd_q),
    .freq_i     (freq_q),
    .phase_i    (phase_q),
    .amp_i      (amp_q),
    .wave_i     (wave_q),
    .en_i       (en_q),
    .lo_i       (lo_q),
    .err_cnt_i  (err_q),
    .drop_cnt_i (drop_q),
    .freq_o     (dec_freq),
    .phase_o    (dec_phase),
    .amp_o      (dec_amp),
    .wave_o     (dec_wave),
    .en_o       (dec_en),
    .lo_o       (dec_lo),
    .update_o   (dec_upd),
    .error_o    (dec_err),
    .reply_o    (dec_reply)
  );

  assign tmo_hit_c = (tmo_q == TMO_W'(REPLY_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // DRAIN holds off until the slave drops its flag so a frame is never re-run.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rd_data_available) state_d = S_EXEC;
      S_EXEC:  state_d = S_REPLY;
      S_REPLY: if (wr_buffer_free || tmo_hit_c) state_d = S_DRAIN;
      S_DRAIN: if (!rd_data_available) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_ack_d   = (state_q == S_IDLE) && rd_data_available;
    wr_en_d    = (state_q == S_REPLY) && wr_buffer_free;
    drop_hit_c = (state_q == S_REPLY) && !wr_buffer_free && tmo_hit_c;
    cfg_upd_d  = (state_q == S_EXEC) && dec_upd;
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_q     <= '0;
      lo_q      <= '0;
      freq_q    <= '0;
      phase_q   <= '0;
      amp_q     <= AMP_RESET;
      wave_q    <= '0;
      en_q      <= 1'b0;
      err_q     <= '0;
      drop_q    <= '0;
      reply_q   <= '0;
      wr_data_q <= '0;
      tmo_q     <= '0;
      rd_ack_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      cfg_upd_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rd_ack_q  <= rd_ack_d;
      wr_en_q   <= wr_en_d;
      cfg_upd_q <= cfg_upd_d;
      busy_q    <= busy_d;
      if (rd_ack_d) cmd_q <= rd_data;
      if (state_q == S_EXEC) begin
        freq_q  <= dec_freq;
        phase_q <= dec_phase;
        amp_q   <= dec_amp;
        wave_q  <= dec_wave;
        en_q    <= dec_en;
        lo_q    <= dec_lo;
        reply_q <= dec_reply;
        if (dec_err && !(&err_q)) err_q <= err_q + CNT_W'(1);
      end
      // Timeout counter restarts every time REPLY is entered.
      if (state_q == S_EXEC)       tmo_q <= '0;
      else if (state_q == S_REPLY) tmo_q <= tmo_q + TMO_W'(1);
      if (drop_hit_c && !(&drop_q)) drop_q <= drop_q + CNT_W'(1);
      if (wr_en_d) wr_data_q <= reply_q;
    end
  end

  assign rd_ack     = rd_ack_q;
  assign wr_en      = wr_en_q;
  assign wr_data    = wr_data_q;
  assign freq_word  = freq_q;
  assign phase_word = phase_q;
  assign amplitude  = amp_q;
  assign wave_sel   = wave_q;
  assign dds_enable = en_q;
  assign cfg_update = cfg_upd_q;
  assign err_cnt    = err_q;
  assign drop_cnt   = drop_q;
  assign busy       = busy_q;

endmodule
